// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART: register map, bit positions,
// minimum baud divider and the serial FSM state types.
package uart_pkg;

   localparam logic [9:0] ADR_DATA  = 10'h000;
   localparam logic [9:0] ADR_STATE = 10'h001;
   localparam logic [9:0] ADR_CTRL  = 10'h002;
   localparam logic [9:0] ADR_INT   = 10'h003;
   localparam logic [9:0] ADR_BAUD  = 10'h004;

   localparam int ST_TX_FULL = 0;
   localparam int ST_RX_FULL = 1;
   localparam int ST_TX_OVR  = 2;
   localparam int ST_RX_OVR  = 3;

   localparam int CTRL_TX_EN  = 0;
   localparam int CTRL_RX_EN  = 1;
   localparam int CTRL_TX_IE  = 2;
   localparam int CTRL_RX_IE  = 3;
   localparam int CTRL_TXO_IE = 4;
   localparam int CTRL_RXO_IE = 5;

   localparam int INT_TX  = 0;
   localparam int INT_RX  = 1;
   localparam int INT_TXO = 2;
   localparam int INT_RXO = 3;

   localparam logic [19:0] MIN_DIV = 20'd16;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // Divider actually used by the baud engines; small values clamp to MIN_DIV.
   function automatic logic [19:0] eff_div(input logic [19:0] div);
      return (div < MIN_DIV) ? MIN_DIV : div;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchroniser, falling-edge start detection with a
// half-bit re-check, then mid-bit sampling of data and stop bits.
module uart_rx
   import uart_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_en,
   input  logic        i_rxd,
   input  logic [19:0] i_div,
   output logic        o_valid,
   output logic [7:0]  o_data
);

   rx_state_e   state_r;
   logic        sync1_r;
   logic        sync2_r;
   logic        prev_r;
   logic [19:0] cnt_r;
   logic [19:0] div_r;
   logic [2:0]  bit_r;
   logic [7:0]  shift_r;
   logic        valid_r;
   logic        half_end_s;
   logic        bit_end_s;

   assign half_end_s = (cnt_r == ((div_r >> 1) - 20'd1));
   assign bit_end_s  = (cnt_r == (div_r - 20'd1));
   assign o_valid    = valid_r;
   assign o_data     = shift_r;

   // Synchroniser and frame sampler; o_valid pulses at the stop-bit sample
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_r <= RX_IDLE;
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
         cnt_r   <= 20'd0;
         div_r   <= MIN_DIV;
         bit_r   <= 3'd0;
         shift_r <= 8'd0;
         valid_r <= 1'b0;
      end else begin
         sync1_r <= i_rxd;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         valid_r <= 1'b0;
         if (!i_en) begin
            state_r <= RX_IDLE;
            cnt_r   <= 20'd0;
         end else begin
            case (state_r)
               RX_IDLE: begin
                  if (prev_r && !sync2_r) begin
                     state_r <= RX_START;
                     cnt_r   <= 20'd0;
                     div_r   <= i_div;
                  end
               end
               RX_START: begin
                  if (half_end_s) begin
                     cnt_r <= 20'd0;
                     div_r <= i_div;
                     bit_r <= 3'd0;
                     state_r <= sync2_r ? RX_IDLE : RX_DATA;
                  end else begin
                     cnt_r <= cnt_r + 20'd1;
                  end
               end
               RX_DATA: begin
                  if (bit_end_s) begin
                     cnt_r   <= 20'd0;
                     div_r   <= i_div;
                     shift_r <= {sync2_r, shift_r[7:1]};
                     if (bit_r == 3'd7) begin
                        state_r <= RX_STOP;
                     end else begin
                        bit_r <= bit_r + 3'd1;
                     end
                  end else begin
                     cnt_r <= cnt_r + 20'd1;
                  end
               end
               RX_STOP: begin
                  if (bit_end_s) begin
                     valid_r <= 1'b1;
                     state_r <= RX_IDLE;
                     cnt_r   <= 20'd0;
                  end else begin
                     cnt_r <= cnt_r + 20'd1;
                  end
               end
               default: begin
                  state_r <= RX_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmit shifter with its own baud counter; the divider is re-latched
// at every bit boundary so BAUDDIV changes apply from the next bit.
module uart_tx
   import uart_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_en,
   input  logic        i_load,
   input  logic [7:0]  i_data,
   input  logic [19:0] i_div,
   output logic        o_idle,
   output logic        o_txd
);

   tx_state_e   state_r;
   logic [19:0] cnt_r;
   logic [19:0] div_r;
   logic [2:0]  bit_r;
   logic [7:0]  shift_r;
   logic        txd_r;
   logic        bit_end_s;

   assign bit_end_s = (cnt_r == (div_r - 20'd1));
   assign o_idle    = (state_r == TX_IDLE);
   assign o_txd     = txd_r;

   // Frame sequencer: start bit, eight data bits LSB first, stop bit
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_r <= TX_IDLE;
         cnt_r   <= 20'd0;
         div_r   <= MIN_DIV;
         bit_r   <= 3'd0;
         shift_r <= 8'd0;
         txd_r   <= 1'b1;
      end else if (!i_en) begin
         state_r <= TX_IDLE;
         cnt_r   <= 20'd0;
         bit_r   <= 3'd0;
         txd_r   <= 1'b1;
      end else begin
         case (state_r)
            TX_IDLE: begin
               if (i_load) begin
                  state_r <= TX_START;
                  shift_r <= i_data;
                  div_r   <= i_div;
                  cnt_r   <= 20'd0;
                  txd_r   <= 1'b0;
               end
            end
            TX_START: begin
               if (bit_end_s) begin
                  state_r <= TX_DATA;
                  cnt_r   <= 20'd0;
                  div_r   <= i_div;
                  bit_r   <= 3'd0;
                  txd_r   <= shift_r[0];
               end else begin
                  cnt_r <= cnt_r + 20'd1;
               end
            end
            TX_DATA: begin
               if (bit_end_s) begin
                  cnt_r   <= 20'd0;
                  div_r   <= i_div;
                  shift_r <= {1'b0, shift_r[7:1]};
                  if (bit_r == 3'd7) begin
                     state_r <= TX_STOP;
                     txd_r   <= 1'b1;
                  end else begin
                     bit_r <= bit_r + 3'd1;
                     txd_r <= shift_r[1];
                  end
               end else begin
                  cnt_r <= cnt_r + 20'd1;
               end
            end
            TX_STOP: begin
               if (bit_end_s) begin
                  state_r <= TX_IDLE;
                  cnt_r   <= 20'd0;
               end else begin
                  cnt_r <= cnt_r + 20'd1;
               end
            end
            default: begin
               state_r <= TX_IDLE;
               txd_r   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/wb_uart.sv
// Wishbone slave UART top: register file, status/interrupt flags and the
// single-cycle registered bus handshake around the TX and RX engines.
module wb_uart
   import uart_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_dev_sel,
   input  logic [9:0]  i_wb_adr,
   input  logic [19:0] i_wb_dat,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_dat,
   output logic        o_wb_ack,
   input  logic        i_rxd,
   output logic        o_txd,
   output logic        o_txen
);

   logic        ack_r;
   logic [31:0] dat_r;
   logic [6:0]  ctrl_r;
   logic [19:0] baud_r;
   logic [7:0]  tx_buf_r;
   logic [7:0]  rx_buf_r;
   logic        tx_full_r;
   logic        rx_full_r;
   logic        tx_ovr_r;
   logic        rx_ovr_r;
   logic [3:0]  int_r;

   logic        req_s, wr_s, rd_s;
   logic        wr_data_s, wr_state_s, wr_ctrl_s, wr_baud_s, wr_int_s, rd_data_s;
   logic [19:0] div_s;
   logic        tx_idle_s, tx_load_s, tx_ovf_s;
   logic        rx_valid_s, rx_store_s, rx_ovf_s;
   logic [7:0]  rx_data_s;
   logic [3:0]  sts_s;
   logic [3:0]  int_set_s;
   logic [31:0] rdata_s;

   assign req_s      = i_dev_sel & i_wb_cyc & ~ack_r;
   assign wr_s       = req_s & i_wb_we;
   assign rd_s       = req_s & ~i_wb_we;
   assign wr_data_s  = wr_s & (i_wb_adr == ADR_DATA);
   assign wr_state_s = wr_s & (i_wb_adr == ADR_STATE);
   assign wr_ctrl_s  = wr_s & (i_wb_adr == ADR_CTRL);
   assign wr_int_s   = wr_s & (i_wb_adr == ADR_INT);
   assign wr_baud_s  = wr_s & (i_wb_adr == ADR_BAUD);
   assign rd_data_s  = rd_s & (i_wb_adr == ADR_DATA);

   assign div_s      = eff_div(baud_r);
   // The shifter load frees the buffer in the same edge a new write lands.
   assign tx_load_s  = ctrl_r[CTRL_TX_EN] & tx_full_r & tx_idle_s;
   assign tx_ovf_s   = wr_data_s & tx_full_r & ~tx_load_s;
   assign rx_store_s = rx_valid_s & ~rx_full_r;
   assign rx_ovf_s   = rx_valid_s & rx_full_r;

   assign o_wb_ack   = ack_r;
   assign o_wb_dat   = dat_r;
   assign o_txen     = ctrl_r[CTRL_TX_EN];

   uart_tx u_tx (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_en   (ctrl_r[CTRL_TX_EN]),
      .i_load (tx_load_s),
      .i_data (tx_buf_r),
      .i_div  (div_s),
      .o_idle (tx_idle_s),
      .o_txd  (o_txd)
   );

   uart_rx u_rx (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_en   (ctrl_r[CTRL_RX_EN]),
      .i_rxd  (i_rxd),
      .i_div  (div_s),
      .o_valid(rx_valid_s),
      .o_data (rx_data_s)
   );

   // Status vector and interrupt set requests for this cycle
   always_comb begin
      sts_s                 = 4'd0;
      sts_s[ST_TX_FULL]     = tx_full_r;
      sts_s[ST_RX_FULL]     = rx_full_r;
      sts_s[ST_TX_OVR]      = tx_ovr_r;
      sts_s[ST_RX_OVR]      = rx_ovr_r;
      int_set_s             = 4'd0;
      int_set_s[INT_TX]     = tx_load_s  & ctrl_r[CTRL_TX_IE];
      int_set_s[INT_RX]     = rx_store_s & ctrl_r[CTRL_RX_IE];
      int_set_s[INT_TXO]    = tx_ovf_s   & ctrl_r[CTRL_TXO_IE];
      int_set_s[INT_RXO]    = rx_ovf_s   & ctrl_r[CTRL_RXO_IE];
   end

   // Read data multiplexer
   always_comb begin
      rdata_s = 32'd0;
      case (i_wb_adr)
         ADR_DATA:  rdata_s = {24'd0, rx_buf_r};
         ADR_STATE: rdata_s = {28'd0, sts_s};
         ADR_CTRL:  rdata_s = {25'd0, ctrl_r};
         ADR_INT:   rdata_s = {28'd0, int_r};
         ADR_BAUD:  rdata_s = {12'd0, baud_r};
         default:   rdata_s = 32'd0;
      endcase
   end

   // Bus handshake, register file and flags; set events win over clears
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ack_r     <= 1'b0;
         dat_r     <= 32'd0;
         ctrl_r    <= 7'd0;
         baud_r    <= 20'd0;
         tx_buf_r  <= 8'd0;
         rx_buf_r  <= 8'd0;
         tx_full_r <= 1'b0;
         rx_full_r <= 1'b0;
         tx_ovr_r  <= 1'b0;
         rx_ovr_r  <= 1'b0;
         int_r     <= 4'd0;
      end else begin
         ack_r <= req_s;
         dat_r <= rd_s ? rdata_s : 32'd0;
         if (wr_ctrl_s) begin
            ctrl_r <= i_wb_dat[6:0];
         end
         if (wr_baud_s) begin
            baud_r <= i_wb_dat;
         end
         if (wr_data_s && !tx_ovf_s) begin
            tx_buf_r <= i_wb_dat[7:0];
         end
         if (rx_store_s) begin
            rx_buf_r <= rx_data_s;
         end
         tx_full_r <= (tx_full_r & ~tx_load_s) | (wr_data_s & ~tx_ovf_s);
         rx_full_r <= (rx_full_r & ~rd_data_s) | rx_valid_s;
         tx_ovr_r  <= (tx_ovr_r & ~(wr_state_s & i_wb_dat[ST_TX_OVR])
                                & ~(wr_int_s & i_wb_dat[INT_TXO])) | tx_ovf_s;
         rx_ovr_r  <= (rx_ovr_r & ~(wr_state_s & i_wb_dat[ST_RX_OVR])
                                & ~(wr_int_s & i_wb_dat[INT_RXO])) | rx_ovf_s;
         int_r     <= (int_r & ~({4{wr_int_s}} & i_wb_dat[3:0])) | int_set_s;
      end
   end

endmodule

// File: tb/tb_wb_uart.sv
// Self-checking bench for wb_uart: register access, TX waveform and decode,
// RX frames, overrun/false-start cases and randomized loop traffic.
module tb_wb_uart;

   localparam logic [9:0] A_DATA  = 10'h000;
   localparam logic [9:0] A_STATE = 10'h001;
   localparam logic [9:0] A_CTRL  = 10'h002;
   localparam logic [9:0] A_INT   = 10'h003;
   localparam logic [9:0] A_BAUD  = 10'h004;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        dev_sel = 1'b0;
   logic [9:0]  wb_adr  = 10'd0;
   logic [19:0] wb_dat  = 20'd0;
   logic        wb_we   = 1'b0;
   logic        wb_cyc  = 1'b0;
   logic        rxd     = 1'b1;
   logic [31:0] wb_rdat;
   logic        wb_ack;
   logic        txd;
   logic        txen;

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clk = ~clk;

   wb_uart dut (
      .i_clk    (clk),
      .i_reset  (rst),
      .i_dev_sel(dev_sel),
      .i_wb_adr (wb_adr),
      .i_wb_dat (wb_dat),
      .i_wb_we  (wb_we),
      .i_wb_cyc (wb_cyc),
      .o_wb_dat (wb_rdat),
      .o_wb_ack (wb_ack),
      .i_rxd    (rxd),
      .o_txd    (txd),
      .o_txen   (txen)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int eff_of(input int baud);
      return (baud < 16) ? 16 : baud;
   endfunction

   task automatic wb_xfer(input logic we, input logic [9:0] adr, input logic [19:0] dat,
                          output logic [31:0] rd);
      @(negedge clk);
      dev_sel = 1'b1; wb_cyc = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat;
      @(posedge clk); #1;
      check_eq("ack", {31'd0, wb_ack}, 32'd1);
      rd = wb_rdat;
      dev_sel = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
      @(posedge clk); #1;
      check_eq("ack_len", {31'd0, wb_ack}, 32'd0);
   endtask

   task automatic wr(input logic [9:0] adr, input logic [19:0] dat);
      logic [31:0] dummy;
      wb_xfer(1'b1, adr, dat, dummy);
   endtask

   task automatic rd_chk(input string tag, input logic [9:0] adr, input logic [31:0] exp);
      logic [31:0] r;
      wb_xfer(1'b0, adr, 20'd0, r);
      check_eq(tag, r, exp);
   endtask

   // Decode one transmitted byte by sampling o_txd at mid-bit.
   task automatic tx_capture(input int eff, output logic [7:0] b);
      int t;
      b = 8'd0;
      @(negedge clk);
      for (t = 0; t < 3000 && txd !== 1'b0; t++) @(negedge clk);
      if (txd !== 1'b0) begin
         check_eq("tx_start_timeout", 32'd0, 32'd1);
      end else begin
         repeat (eff / 2) @(negedge clk);
         check_eq("tx_startbit", {31'd0, txd}, 32'd0);
         for (int k = 0; k < 8; k++) begin
            repeat (eff) @(negedge clk);
            b[k] = txd;
         end
         repeat (eff) @(negedge clk);
         check_eq("tx_stopbit", {31'd0, txd}, 32'd1);
      end
   endtask

   task automatic rx_send(input logic [7:0] b, input int eff);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         rxd = fr[k];
         repeat (eff) @(negedge clk);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] got_b;
      logic [9:0] fr;
      int         t;
      int         baud;
      int         eff;
      logic [7:0] byte_v;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_txd", {31'd0, txd}, 32'd1);
      check_eq("rst_txen", {31'd0, txen}, 32'd0);
      check_eq("rst_ack", {31'd0, wb_ack}, 32'd0);
      check_eq("rst_dat", wb_rdat, 32'd0);
      rst = 1'b0;
      rd_chk("rst_state", A_STATE, 32'd0);
      rd_chk("rst_ctrl", A_CTRL, 32'd0);
      rd_chk("rst_baud", A_BAUD, 32'd0);
      rd_chk("rst_int", A_INT, 32'd0);
      rd_chk("unmapped", 10'h155, 32'd0);

      // Transmit 0xA5 at 16 clocks/bit, checking bit edges of the waveform
      wr(A_BAUD, 20'd16);
      wr(A_CTRL, 20'h1);
      check_eq("txen", {31'd0, txen}, 32'd1);
      wr(A_DATA, 20'hA5);
      fr = {1'b1, 8'hA5, 1'b0};
      @(negedge clk);
      for (t = 0; t < 100 && txd !== 1'b0; t++) @(negedge clk);
      check_eq("a5_start_seen", {31'd0, txd}, 32'd0);
      for (int k = 0; k < 160; k++) begin
         if ((k % 16) == 0 || (k % 16) == 15) begin
            check_eq($sformatf("a5_bit%0d_s%0d", k / 16, k % 16), {31'd0, txd}, {31'd0, fr[k / 16]});
         end
         @(negedge clk);
      end
      check_eq("a5_idle", {31'd0, txd}, 32'd1);
      rd_chk("a5_state", A_STATE, 32'd0);
      rd_chk("a5_int", A_INT, 32'd0);

      // TX overrun with transmitter disabled
      wr(A_CTRL, 20'h0);
      wr(A_DATA, 20'h11);
      wr(A_DATA, 20'h22);
      rd_chk("ovr_state", A_STATE, 32'h5);
      repeat (40) @(negedge clk);
      check_eq("ovr_hold_txd", {31'd0, txd}, 32'd1);
      wr(A_CTRL, 20'h1);
      tx_capture(16, got_b);
      check_eq("ovr_byte", {24'd0, got_b}, 32'h11);
      rd_chk("ovr_state2", A_STATE, 32'h4);
      rd_chk("ovr_int", A_INT, 32'h0);
      wr(A_STATE, 20'h4);
      rd_chk("ovr_cleared", A_STATE, 32'h0);

      // Receive 0x3C at 20 clocks/bit
      wr(A_BAUD, 20'd20);
      wr(A_CTRL, 20'h0A);
      rx_send(8'h3C, 20);
      rd_chk("rx_state", A_STATE, 32'h2);
      rd_chk("rx_int", A_INT, 32'h2);
      rd_chk("rx_data", A_DATA, 32'h3C);
      rd_chk("rx_state_clr", A_STATE, 32'h0);
      wr(A_INT, 20'hF);

      // RX overrun keeps the first byte
      wr(A_CTRL, 20'h2A);
      rx_send(8'h5A, 20);
      rx_send(8'hC3, 20);
      rd_chk("rxo_state", A_STATE, 32'hA);
      rd_chk("rxo_int", A_INT, 32'hA);
      rd_chk("rxo_data", A_DATA, 32'h5A);
      rd_chk("rxo_state2", A_STATE, 32'h8);
      wr(A_INT, 20'h8);
      rd_chk("rxo_state3", A_STATE, 32'h0);
      rd_chk("rxo_int2", A_INT, 32'h2);
      wr(A_INT, 20'h2);

      // 3-clock glitch is a false start
      @(negedge clk);
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (80) @(negedge clk);
      rd_chk("glitch_state", A_STATE, 32'h0);
      rd_chk("glitch_int", A_INT, 32'h0);

      // Randomized TX and RX bytes at random dividers (first one below 16)
      wr(A_CTRL, 20'h07);
      for (int i = 0; i < 5; i++) begin
         baud   = (i == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(16, 28));
         eff    = eff_of(baud);
         byte_v = 8'($urandom);
         wr(A_BAUD, 20'(baud));
         rd_chk("rnd_baud", A_BAUD, 32'(baud));
         wr(A_DATA, {12'd0, byte_v});
         tx_capture(eff, got_b);
         check_eq("rnd_tx_byte", {24'd0, got_b}, {24'd0, byte_v});
         rd_chk("rnd_tx_int", A_INT, 32'h1);
         wr(A_INT, 20'h1);
         byte_v = 8'($urandom);
         rx_send(byte_v, eff);
         rd_chk("rnd_rx_state", A_STATE, 32'h2);
         rd_chk("rnd_rx_int", A_INT, 32'h0);
         rd_chk("rnd_rx_data", A_DATA, {24'd0, byte_v});
      end

      // Reset mid-frame aborts transmission at once
      wr(A_BAUD, 20'd16);
      wr(A_CTRL, 20'h1);
      wr(A_DATA, 20'h00);
      repeat (30) @(negedge clk);
      check_eq("mid_txd_low", {31'd0, txd}, 32'd0);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_txd", {31'd0, txd}, 32'd1);
      check_eq("mid_rst_txen", {31'd0, txen}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rd_chk("mid_rst_state", A_STATE, 32'h0);
      rd_chk("mid_rst_ctrl", A_CTRL, 32'h0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
